panda_regfile_sb: RTL and testbench
===================================

Name: panda_regfile_sb

Overview:
Parametrised integer register file for Panda cores with multiple read and write ports, optional same-cycle write-to-read bypass, and an integrated per-register scoreboard of busy bits. The decode/issue stage reads operands and checks the busy bits. The writeback stage(s) write results and clear the busy bits. Register x0 is hardwired to zero and is never busy. The same block serves RV32I (32 regs) and RV32E (16 regs).

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, register count; legal values 16 or 32; AW = $clog2(NUM_REGS)
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
BYPASS, 1, 1 = read data and busy reflect same-cycle writes; 0 = registered values only

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
rd_addr_i  in  NUM_RD x AW  read port addresses
rd_data_o  out  NUM_RD x XLEN  read data (combinational)
rd_busy_o  out  NUM_RD  addressed register has an outstanding write
wr_en_i  in  NUM_WR  write enables
wr_addr_i  in  NUM_WR x AW  write addresses
wr_data_i  in  NUM_WR x XLEN  write data
issue_en_i  in  1  mark issue_addr_i busy (new in-flight producer)
issue_addr_i  in  AW  destination register being issued
flush_i  in  1  clear all busy bits (pipeline flush)
busy_o  out  NUM_REGS  full scoreboard vector, registered
wr_conflict_o  out  1  sticky error: two write ports hit the same nonzero register in one cycle

Behaviour:
- Reset (asynchronous, rst_ni low):
  - All registers = 0.
  - busy_q = 0.
  - wr_conflict_o = 0.
  - rd_data_o = 0 and rd_busy_o = 0 for any address while reset is held.
- Register array is indices 1..NUM_REGS-1. Index 0 is not stored.
  - Reads of address 0 return 0 with busy 0.
  - Writes or issues to address 0 are ignored.
- Write (registered): on a rising edge with wr_en_i[k] and wr_addr_i[k] != 0, reg[wr_addr_i[k]] <= wr_data_i[k]. Visible next cycle when BYPASS=0.
- Multiple write ports on the same address in the same cycle:
  - The highest-index port wins.
  - If the address is nonzero, wr_conflict_o sets and stays 1 until reset.
- Read (combinational, zero latency):
  - BYPASS=1: if any enabled write port matches rd_addr_i[j] (nonzero), rd_data_o[j] = that port's wr_data_i, using the highest-index port on a tie.
  - Otherwise rd_data_o[j] = stored value.
- Scoreboard next-state per register r (r != 0), in priority order:
  1. flush_i → busy <= 0. flush overrides issue in the same cycle.
  2. issue_en_i and issue_addr_i == r → busy <= 1. Set wins over a same-cycle clear, because the new producer supersedes the one writing back.
  3. Any enabled write port hits r → busy <= 0.
  4. Otherwise hold.
- busy_o is busy_q. Bit 0 is always 0.
- rd_busy_o[j]:
  - BYPASS=0: busy_q[rd_addr_i[j]].
  - BYPASS=1: busy_q[addr] AND NOT (an enabled write hits addr this cycle).
  - A same-cycle issue does not affect rd_busy_o until the next cycle.
- Writes to a non-busy register are legal: data is updated and busy stays 0.
- Reset asserted mid-operation clears everything immediately. In-flight writes present during reset are discarded.
- Implementation constraints:
  - Purely register-based storage, no SRAM macros.
  - No combinational path from issue_* or flush_i to rd_data_o.
  - Parameters outside their legal range are rejected by an elaboration-time assertion.

Test Plan:
1. Reset, then read all addresses on every port → data 0, busy 0, busy_o = 0, wr_conflict_o = 0.
2. Write x5 = 32'hDEAD_BEEF via port 0 with BYPASS=1, reading x5 in the same cycle on port 1 → rd_data_o[1] = DEAD_BEEF in that cycle. With BYPASS=0 the same cycle shows the old value 0, and DEAD_BEEF appears the next cycle.
3. Write 32'h1234 to x0 and issue x0 → reads of x0 return 0, busy_o[0] stays 0.
4. Issue x7; one cycle later read x7 → rd_busy_o = 1. Write x7 = 9 via port 1 with BYPASS=1 → rd_busy_o = 0 and data = 9 in that cycle; busy_o[7] = 0 next cycle.
5. Issue x3 and write x3 in the same cycle → busy_o[3] = 1 next cycle and data updated. Then assert flush_i together with issue x4 → busy_o all 0 next cycle.
6. Ports 0 and 1 both write x9 (values 1 and 2) → x9 = 2 and wr_conflict_o = 1, held until reset. Both ports writing x0 → no conflict flag.

Source files
------------

// File: rtl/panda_regfile_sb.sv
// panda_regfile_sb
// Integer register file with an integrated busy-bit scoreboard for Panda cores.
// x0 is hardwired to zero and never busy. Storage covers x1..x(NUM_REGS-1).
// Serves RV32I (NUM_REGS=32) and RV32E (NUM_REGS=16).
//
// Ports (port k of a flattened bus occupies bits [k*W +: W]):
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   rd_addr_i      NUM_RD read addresses
//   rd_data_o      NUM_RD read data words (combinational)
//   rd_busy_o      per read port: addressed register has an outstanding write
//   wr_en_i        NUM_WR write enables
//   wr_addr_i      NUM_WR write addresses
//   wr_data_i      NUM_WR write data words
//   issue_en_i     mark issue_addr_i busy
//   issue_addr_i   destination register being issued
//   flush_i        clear every busy bit
//   busy_o         registered scoreboard vector (bit 0 always 0)
//   wr_conflict_o  sticky: two write ports hit the same nonzero register
module panda_regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*AW-1:0]     wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
    input  logic                     issue_en_i,
    input  logic [AW-1:0]            issue_addr_i,
    input  logic                     flush_i,
    output logic [NUM_REGS-1:0]      busy_o,
    output logic                     wr_conflict_o
);

    if (!(NUM_REGS == 16 || NUM_REGS == 32)) begin : g_bad_num_regs
        $error("panda_regfile_sb: NUM_REGS must be 16 or 32");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("panda_regfile_sb: NUM_RD must be 1..4");
    end
    if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_num_wr
        $error("panda_regfile_sb: NUM_WR must be 1..2");
    end
    if (!(BYPASS == 0 || BYPASS == 1)) begin : g_bad_bypass
        $error("panda_regfile_sb: BYPASS must be 0 or 1");
    end
    if (XLEN < 1) begin : g_bad_xlen
        $error("panda_regfile_sb: XLEN must be positive");
    end

    logic [XLEN-1:0]     regs_q [1:NUM_REGS-1];
    logic [XLEN-1:0]     regs_d [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                wr_conflict_q;
    logic                wr_conflict_d;
    logic [NUM_REGS-1:0] wr_hit;
    logic                conflict_now;

    // Which registers are written this cycle; bit 0 never set since x0 is not stored.
    always_comb begin
        wr_hit = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en_i[k] && wr_addr_i[k*AW +: AW] == AW'(r)) begin
                    wr_hit[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        conflict_now = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            for (int m = k + 1; m < NUM_WR; m++) begin
                if (wr_en_i[k] && wr_en_i[m] &&
                    wr_addr_i[k*AW +: AW] == wr_addr_i[m*AW +: AW] &&
                    wr_addr_i[k*AW +: AW] != '0) begin
                    conflict_now = 1'b1;
                end
            end
        end
        wr_conflict_d = wr_conflict_q | conflict_now;
    end

    // Ascending port order lets the highest-index port win a same-address tie.
    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en_i[k] && wr_addr_i[k*AW +: AW] == AW'(r)) begin
                    regs_d[r] = wr_data_i[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Issue beats writeback: the newly issued producer supersedes the one retiring.
    always_comb begin
        busy_d = busy_q;
        busy_d[0] = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (issue_en_i && issue_addr_i == AW'(r)) begin
                busy_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Read ports see only stored state and write-port inputs, never issue/flush.
    // Outputs are forced to zero while reset is held so bypassed write data cannot leak.
    always_comb begin
        logic [AW-1:0]   raddr;
        logic [XLEN-1:0] rdata;
        logic            rbusy;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            raddr = rd_addr_i[j*AW +: AW];
            rdata = '0;
            rbusy = 1'b0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (raddr == AW'(r)) begin
                    rdata = regs_q[r];
                    rbusy = busy_q[r];
                end
            end
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_en_i[k] && raddr != '0 && wr_addr_i[k*AW +: AW] == raddr) begin
                        rdata = wr_data_i[k*XLEN +: XLEN];
                        rbusy = 1'b0;
                    end
                end
            end
            if (!rst_ni) begin
                rdata = '0;
                rbusy = 1'b0;
            end
            rd_data_o[j*XLEN +: XLEN] = rdata;
            rd_busy_o[j]              = rbusy;
        end
    end

    assign busy_o        = busy_q;
    assign wr_conflict_o = wr_conflict_q;

endmodule

// File: tb/tb_panda_regfile_sb.sv
// Directed bench for panda_regfile_sb: one BYPASS=1 and one BYPASS=0 instance
// share stimulus; a reference model produces expectations into a scoreboard queue.
module tb_panda_regfile_sb;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        flush;
    logic [31:0] busy, busy_nb;
    logic        conf, conf_nb;

    logic [4:0]  ra [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];

    always_comb begin
        rd_addr = {ra[1], ra[0]};
        wr_addr = {wa[1], wa[0]};
        wr_data = {wd[1], wd[0]};
    end

    always #5 clk_i = ~clk_i;

    panda_regfile_sb #(.BYPASS(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .flush_i(flush),
        .busy_o(busy), .wr_conflict_o(conf)
    );

    panda_regfile_sb #(.BYPASS(0)) dut_nb (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb), .rd_busy_o(rd_busy_nb),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .flush_i(flush),
        .busy_o(busy_nb), .wr_conflict_o(conf_nb)
    );

    // Reference model
    logic [31:0] m_reg [32];
    logic [31:0] m_busy;
    logic        m_conf;

    typedef struct {
        int          step;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int step  = 0;

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) m_reg[r] = '0;
        m_busy = '0;
        m_conf = 1'b0;
    endfunction

    function automatic logic [31:0] exp_rdata(int j, bit byp);
        logic [31:0] v;
        logic [4:0]  a;
        a = ra[j];
        if (!rst_ni) return '0;
        v = (a == 0) ? 32'h0 : m_reg[a];
        if (byp && a != 0)
            for (int k = 0; k < 2; k++)
                if (wr_en[k] && wa[k] == a) v = wd[k];
        return v;
    endfunction

    function automatic logic [31:0] exp_rbusy(int j, bit byp);
        logic       b;
        logic [4:0] a;
        a = ra[j];
        if (!rst_ni || a == 0) return '0;
        b = m_busy[a];
        if (byp)
            for (int k = 0; k < 2; k++)
                if (wr_en[k] && wa[k] == a) b = 1'b0;
        return {31'b0, b};
    endfunction

    function automatic void model_commit();
        logic [31:0] hit;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        hit = '0;
        for (int k = 0; k < 2; k++)
            if (wr_en[k] && wa[k] != 0) hit[wa[k]] = 1'b1;
        if (wr_en[0] && wr_en[1] && wa[0] == wa[1] && wa[0] != 0) m_conf = 1'b1;
        for (int k = 0; k < 2; k++)
            if (wr_en[k] && wa[k] != 0) m_reg[wa[k]] = wd[k];
        for (int r = 1; r < 32; r++) begin
            if (flush) m_busy[r] = 1'b0;
            else if (issue_en && issue_addr == 5'(r)) m_busy[r] = 1'b1;
            else if (hit[r]) m_busy[r] = 1'b0;
        end
    endfunction

    function automatic logic [31:0] observe(int kind, int idx);
        case (kind)
            0: return rd_data[idx*32 +: 32];
            1: return {31'b0, rd_busy[idx]};
            2: return rd_data_nb[idx*32 +: 32];
            3: return {31'b0, rd_busy_nb[idx]};
            4: return busy;
            5: return {31'b0, conf};
            6: return busy_nb;
            default: return {31'b0, conf_nb};
        endcase
    endfunction

    function automatic string kind_name(int kind);
        case (kind)
            0: return "rd_data";
            1: return "rd_busy";
            2: return "nb_rd_data";
            3: return "nb_rd_busy";
            4: return "busy_o";
            5: return "wr_conflict";
            6: return "nb_busy_o";
            default: return "nb_wr_conflict";
        endcase
    endfunction

    function automatic void push(int kind, int idx, logic [31:0] e);
        exp_t x;
        x.step = step; x.kind = kind; x.idx = idx; x.exp = e;
        sb.push_back(x);
    endfunction

    // Expectations are queued at drive time, then popped once outputs have settled.
    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        for (int j = 0; j < 2; j++) begin
            push(0, j, exp_rdata(j, 1'b1));
            push(1, j, exp_rbusy(j, 1'b1));
            push(2, j, exp_rdata(j, 1'b0));
            push(3, j, exp_rbusy(j, 1'b0));
        end
        push(4, 0, rst_ni ? m_busy : 32'h0);
        push(5, 0, {31'b0, rst_ni ? m_conf : 1'b0});
        push(6, 0, rst_ni ? m_busy : 32'h0);
        push(7, 0, {31'b0, rst_ni ? m_conf : 1'b0});
        #2;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind, e.idx);
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL step%0d %s[%0d] got=%h exp=%h",
                       e.step, kind_name(e.kind), e.idx, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        wr_en    = 2'b00;
        issue_en = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni     = 1'b0;
        ra[0] = 5'd5; ra[1] = 5'd0;
        wa[0] = 5'd5; wa[1] = 5'd0;
        wd[0] = 32'hCAFE_0001; wd[1] = '0;
        wr_en      = 2'b01;
        issue_en   = 1'b1;
        issue_addr = 5'd6;
        flush      = 1'b0;
        model_reset();

        // Reset held: outputs zero even with a live bypassable write
        step = 1;
        #3 check_all();
        tick();
        check_all();
        idle();
        rst_ni = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            ra[0] = 5'(a);
            ra[1] = 5'(31 - a);
            check_all();
        end
        tick();

        // Write x5 with same-cycle read on port 1
        step = 2;
        wr_en = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF;
        ra[0] = 5'd0; ra[1] = 5'd5;
        check_all();
        tick();
        idle();
        check_all();

        // Writes and issues to x0 are ignored
        step = 3;
        wr_en = 2'b01; wa[0] = 5'd0; wd[0] = 32'h1234;
        issue_en = 1'b1; issue_addr = 5'd0;
        ra[0] = 5'd0; ra[1] = 5'd0;
        check_all();
        tick();
        idle();
        check_all();

        // Issue x7, then retire it through port 1
        step = 4;
        issue_en = 1'b1; issue_addr = 5'd7;
        ra[0] = 5'd7; ra[1] = 5'd5;
        check_all();
        tick();
        idle();
        check_all();
        wr_en = 2'b10; wa[1] = 5'd7; wd[1] = 32'd9;
        check_all();
        tick();
        idle();
        check_all();

        // Issue and write x3 together; then flush with a competing issue
        step = 5;
        issue_en = 1'b1; issue_addr = 5'd3;
        wr_en = 2'b01; wa[0] = 5'd3; wd[0] = 32'h0000_0055;
        ra[0] = 5'd3; ra[1] = 5'd4;
        check_all();
        tick();
        idle();
        check_all();
        issue_en = 1'b1; issue_addr = 5'd12;
        tick();
        idle();
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd4;
        check_all();
        tick();
        idle();
        check_all();

        // Same-address double write: highest port wins, sticky conflict
        step = 6;
        wr_en = 2'b11; wa[0] = 5'd9; wa[1] = 5'd9; wd[0] = 32'd1; wd[1] = 32'd2;
        ra[0] = 5'd9; ra[1] = 5'd3;
        check_all();
        tick();
        idle();
        check_all();
        for (int i = 0; i < 3; i++) begin
            wr_en = 2'b01; wa[0] = 5'd10; wd[0] = 32'(i + 100);
            ra[1] = 5'd10;
            tick();
            idle();
            check_all();
        end
        rst_ni = 1'b0;
        model_reset();
        check_all();
        tick();
        rst_ni = 1'b1;
        wr_en = 2'b11; wa[0] = 5'd0; wa[1] = 5'd0; wd[0] = 32'hAA; wd[1] = 32'hBB;
        ra[0] = 5'd0; ra[1] = 5'd9;
        check_all();
        tick();
        idle();
        check_all();

        // Asynchronous reset mid-operation discards state and in-flight writes
        step = 7;
        issue_en = 1'b1; issue_addr = 5'd10;
        wr_en = 2'b01; wa[0] = 5'd11; wd[0] = 32'h0000_00AA;
        tick();
        issue_en = 1'b0;
        ra[0] = 5'd11; ra[1] = 5'd10;
        wr_en = 2'b11; wa[0] = 5'd11; wa[1] = 5'd10; wd[0] = 32'h11; wd[1] = 32'h22;
        check_all();
        rst_ni = 1'b0;
        model_reset();
        check_all();
        tick();
        rst_ni = 1'b1;
        idle();
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
